// File: rtl/elev_pkg.sv
// Shared types for the elevator car controller: request codes, FSM states,
// floor type and the request-code-to-floor decode.
package elev_pkg;

  localparam logic [2:0] REQ_NONE = 3'b000;
  localparam logic [2:0] REQ_1U   = 3'b001;
  localparam logic [2:0] REQ_2U   = 3'b010;
  localparam logic [2:0] REQ_3U   = 3'b011;
  localparam logic [2:0] REQ_4D   = 3'b100;
  localparam logic [2:0] REQ_BAD  = 3'b101;
  localparam logic [2:0] REQ_2D   = 3'b110;
  localparam logic [2:0] REQ_3D   = 3'b111;

  typedef logic [1:0] floor_t;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    CAPTURE,
    MOVE,
    DOOR_OPEN,
    DOOR_CLOSE
  } state_t;

  function automatic logic req_valid(input logic [2:0] code);
    return (code != REQ_NONE) && (code != REQ_BAD);
  endfunction

  function automatic floor_t code_to_floor(input logic [2:0] code);
    floor_t f;
    case (code)
      REQ_1U:         f = 2'd0;
      REQ_2U, REQ_2D: f = 2'd1;
      REQ_3U, REQ_3D: f = 2'd2;
      REQ_4D:         f = 2'd3;
      default:        f = 2'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/elev_car_ctrl_if.sv
// Request-buffer / car-status bundle between the hall-call side and the car controller.
interface elev_car_ctrl_if;
  import elev_pkg::*;

  logic       q_empty;
  logic [2:0] req;
  logic       door_obst;
  logic       done;
  floor_t     floor;
  logic       motor_up;
  logic       motor_dn;
  logic       door_open;
  logic       dir_ind;

  modport master (
    output q_empty, req, door_obst,
    input  done, floor, motor_up, motor_dn, door_open, dir_ind
  );

  modport slave (
    input  q_empty, req, door_obst,
    output done, floor, motor_up, motor_dn, door_open, dir_ind
  );

endinterface

// File: rtl/elev_tick_timer.sv
// Loadable down-counter that parks at zero; expire flags the zero count so the
// owner can act on the cycle the count runs out.
module elev_tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign expire = (count_reg == '0);

endmodule

// File: rtl/elev_car_ctrl.sv
// Car motion/door controller: pulls one request, drives floor by floor, runs the door cycle.
// Optional door re-open on obstruction is enabled by defining ELEV_DOOR_REOPEN_EN.
module elev_car_ctrl
  import elev_pkg::*;
#(
  parameter int FLOOR_TICKS = 8,
  parameter int DOOR_TICKS  = 4,
  parameter int CNT_W       = 8
) (
  input logic           clk,
  input logic           rst_n,
  elev_car_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FLOOR_LOAD = CNT_W'(FLOOR_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD  = CNT_W'(DOOR_TICKS - 1);

  state_t     state_reg, state_next;
  floor_t     floor_reg, floor_next;
  floor_t     target_reg, target_next;
  logic       done_reg, done_next;
  logic       up_reg, up_next;
  logic       dn_reg, dn_next;
  logic       door_reg, door_next;
  logic       dir_reg, dir_next;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_expire;
  logic             obst_hit;
  floor_t           cap_floor;
  floor_t           step_floor;

`ifdef ELEV_DOOR_REOPEN_EN
  assign obst_hit = bus.door_obst;
`else
  logic unused_door_obst;
  assign obst_hit         = 1'b0;
  assign unused_door_obst = bus.door_obst;
`endif

  elev_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      floor_reg  <= '0;
      target_reg <= '0;
      done_reg   <= 1'b0;
      up_reg     <= 1'b0;
      dn_reg     <= 1'b0;
      door_reg   <= 1'b0;
      dir_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      floor_reg  <= floor_next;
      target_reg <= target_next;
      done_reg   <= done_next;
      up_reg     <= up_next;
      dn_reg     <= dn_next;
      door_reg   <= door_next;
      dir_reg    <= dir_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    floor_next  = floor_reg;
    target_next = target_reg;
    done_next   = 1'b0;
    up_next     = up_reg;
    dn_next     = dn_reg;
    door_next   = door_reg;
    dir_next    = dir_reg;
    timer_load  = 1'b0;
    timer_val   = FLOOR_LOAD;
    cap_floor   = code_to_floor(bus.req);
    step_floor  = floor_reg;

    case (state_reg)
      IDLE: begin
        if (!bus.q_empty) begin
          state_next = GRANT;
          done_next  = 1'b1;
        end
      end
      GRANT: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        if (req_valid(bus.req)) begin
          target_next = cap_floor;
          dir_next    = bus.req[2];
          timer_load  = 1'b1;
          if (cap_floor > floor_reg) begin
            state_next = MOVE;
            up_next    = 1'b1;
          end else if (cap_floor < floor_reg) begin
            state_next = MOVE;
            dn_next    = 1'b1;
          end else begin
            state_next = DOOR_OPEN;
            door_next  = 1'b1;
            timer_val  = DOOR_LOAD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      MOVE: begin
        if (timer_expire) begin
          // Saturate at the shaft ends even though a legal target never asks past them.
          if (up_reg) begin
            step_floor = (floor_reg == 2'd3) ? floor_reg : floor_reg + 2'd1;
          end else begin
            step_floor = (floor_reg == 2'd0) ? floor_reg : floor_reg - 2'd1;
          end
          floor_next = step_floor;
          timer_load = 1'b1;
          if (step_floor == target_reg) begin
            state_next = DOOR_OPEN;
            up_next    = 1'b0;
            dn_next    = 1'b0;
            door_next  = 1'b1;
            timer_val  = DOOR_LOAD;
          end
        end
      end
      DOOR_OPEN: begin
        if (obst_hit) begin
          timer_load = 1'b1;
          timer_val  = DOOR_LOAD;
        end else if (timer_expire) begin
          state_next = DOOR_CLOSE;
          door_next  = 1'b0;
          timer_load = 1'b1;
          timer_val  = DOOR_LOAD;
        end
      end
      DOOR_CLOSE: begin
        if (obst_hit) begin
          state_next = DOOR_OPEN;
          door_next  = 1'b1;
          timer_load = 1'b1;
          timer_val  = DOOR_LOAD;
        end else if (timer_expire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.done      = done_reg;
  assign bus.floor     = floor_reg;
  assign bus.motor_up  = up_reg;
  assign bus.motor_dn  = dn_reg;
  assign bus.door_open = door_reg;
  assign bus.dir_ind   = dir_reg;

endmodule

// File: tb/tb_elev_car_ctrl.sv
// Directed and randomized checks of elev_car_ctrl against a timeline model of each request.
module tb_elev_car_ctrl;

  localparam int FT = 5;
  localparam int DT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elev_car_ctrl_if bus();

  elev_car_ctrl #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   mdl_floor = 0;
  logic mdl_dir = 1'b0;

  function automatic logic [6:0] expv(input logic d, input int f, input logic up,
                                      input logic dn, input logic door, input logic dir);
    logic [1:0] fl;
    fl = 2'(f);
    return {d, fl, up, dn, door, dir};
  endfunction

  function automatic int dest_of(input logic [2:0] code);
    int r;
    r = -1;
    if (code == 3'b001) r = 0;
    if (code == 3'b010 || code == 3'b110) r = 1;
    if (code == 3'b011 || code == 3'b111) r = 2;
    if (code == 3'b100) r = 3;
    return r;
  endfunction

  task automatic check(input string tag, input int k, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {bus.done, bus.floor, bus.motor_up, bus.motor_dn, bus.door_open, bus.dir_ind};
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
  endtask

  // Obstruction is noise to be ignored unless the re-open feature is built in.
  task automatic tick();
    @(posedge clk);
    #1;
`ifndef ELEV_DOOR_REOPEN_EN
    bus.door_obst = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    bus.q_empty = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      tick();
      if (bus.done === 1'b1) ok = 1;
    end
    total_cnt++;
    assert (ok) pass_cnt++;
    else $error("FAIL done_timeout observed=0 expected=1");
    if (ok) check("grant", 0, expv(1'b1, mdl_floor, 1'b0, 1'b0, 1'b0, mdl_dir));
  endtask

  // Returns with the sample point just after the edge that consumed the request.
  task automatic capture(input logic [2:0] code);
    bus.q_empty = 1'b1;
    tick();
    bus.req = code;
    check("done_once", 0, expv(1'b0, mdl_floor, 1'b0, 1'b0, 1'b0, mdl_dir));
    tick();
    bus.req = 3'($urandom);
  endtask

  task automatic follow(input logic [2:0] code, input int stop_k);
    int tgt, d, m, f, start;
    logic door, dir;
    tgt = dest_of(code);
    start = mdl_floor;
    if (tgt < 0) begin
      check("invalid", 0, expv(1'b0, mdl_floor, 1'b0, 1'b0, 1'b0, mdl_dir));
      $display("tx req=%b ignored at floor %0d", code, mdl_floor);
      return;
    end
    d = tgt - mdl_floor;
    m = ((d < 0) ? -d : d) * FT;
    dir = code[2];
    for (int k = 0; k <= m + 2 * DT; k++) begin
      if (k == stop_k) return;
      if (k < m) begin
        f = mdl_floor + ((d > 0) ? (k / FT) : -(k / FT));
        check("travel", k, expv(1'b0, f, d > 0, d < 0, 1'b0, dir));
      end else begin
        door = (k < m + DT);
        check("door", k, expv(1'b0, tgt, 1'b0, 1'b0, door, dir));
      end
      if (k < m + 2 * DT) tick();
    end
    mdl_floor = tgt;
    mdl_dir = dir;
    $display("tx req=%b floor %0d->%0d", code, start, tgt);
  endtask

  task automatic do_req(input logic [2:0] code);
    wait_done();
    capture(code);
    follow(code, -1);
  endtask

  initial begin
    logic [2:0] code;
    bus.q_empty = 1'b1;
    bus.req = 3'b000;
    bus.door_obst = 1'b0;

    // Reset and a quiet buffer: nothing may move.
    tick();
    tick();
    check("reset", 0, expv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("quiet", k, expv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    $display("tx reset idle 20 cycles");

    do_req(3'b100);
    do_req(3'b001);
    do_req(3'b010);
    do_req(3'b010);

    // Invalid codes go straight back to IDLE; done re-pulses only with a pending request.
    do_req(3'b000);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("empty_hold", k, expv(1'b0, mdl_floor, 1'b0, 1'b0, 1'b0, mdl_dir));
    end
    do_req(3'b101);
    bus.q_empty = 1'b0;
    tick();
    check("repulse", 0, expv(1'b1, mdl_floor, 1'b0, 1'b0, 1'b0, mdl_dir));
    capture(3'b011);
    follow(3'b011, -1);

    // Reset while leaving floor 2 on the way up.
    wait_done();
    capture(3'b100);
    follow(3'b100, 2);
    rst_n = 1'b0;
    tick();
    check("reset_move", 0, expv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    mdl_floor = 0;
    mdl_dir = 1'b0;
    tick();
    check("after_reset", 0, expv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    $display("tx reset mid-move");

`ifdef ELEV_DOOR_REOPEN_EN
    wait_done();
    capture(3'b001);
    for (int k = 0; k <= 3 * DT + 1; k++) begin
      if (k == DT) begin
        check("closing", k, expv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.door_obst = 1'b1;
        tick();
        bus.door_obst = 1'b0;
      end else begin
        check("reopen", k, expv(1'b0, 0, 1'b0, 1'b0,
                                (k < DT) || (k > DT && k <= 2 * DT), 1'b0));
        if (k < 3 * DT + 1) tick();
      end
    end
    $display("tx door reopen on obstruction");
`endif

    for (int i = 0; i < 30; i++) begin
      code = 3'($urandom_range(0, 7));
      do_req(code);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
